rd_empty_stage: RTL and testbench

RD_EMPTY_STAGE -- requirements
Module: rd_empty_stage

---
 rtl/rd_empty_stage.sv | 149 ++++++++++++++
 tb/tb_rd_empty_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_empty_stage.sv
// Read-side stage of an async FIFO: synchronises the write pointer, issues RAM reads
// and delivers words through a 2-entry output buffer. Optional level output: RD_LEVEL_EN.
module rd_empty_stage #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     r_clk,
  input  logic                     rst,
  input  logic [$clog2(DEPTH):0]   wptr_async,
  input  logic [WIDTH-1:0]         rdata,
  input  logic                     dout_ready,
  output logic                     ren,
  output logic [$clog2(DEPTH)-1:0] raddr,
  output logic [$clog2(DEPTH):0]   rptr,
  output logic                     empty,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  output logic [$clog2(DEPTH):0]   rlevel
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    r_wq1;
  logic [PW-1:0]    r_wq2;
  logic [PW-1:0]    r_rbin;
  logic [PW-1:0]    r_rptr;
  logic             r_empty;
  logic             r_inflight;
  logic [1:0]       r_occ;
  logic [WIDTH-1:0] r_buf0;
  logic [WIDTH-1:0] r_buf1;

  logic             w_valid;
  logic             w_pop;
  logic             w_ren;
  logic [2:0]       w_fill;
  logic [PW-1:0]    w_rbin_next;
  logic [PW-1:0]    w_rgray_next;

  // Two-flop synchroniser; r_wq2 is the only consumer of the write pointer
  always_ff @(posedge r_clk) begin
    if (rst) begin
      r_wq1 <= '0;
      r_wq2 <= '0;
    end else begin
      r_wq1 <= wptr_async;
      r_wq2 <= r_wq1;
    end
  end

  // Fetch only while buffer slots plus the in-flight read leave room for one more word
  always_comb begin
    w_valid      = 1'b0;
    w_pop        = 1'b0;
    w_fill       = 3'd0;
    w_ren        = 1'b0;
    w_rbin_next  = r_rbin;
    w_rgray_next = '0;

    w_valid      = ~rst & (r_occ != 2'd0);
    w_pop        = w_valid & dout_ready;
    w_fill       = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_ren        = ~rst & ~r_empty & (w_fill <= 3'd1);
    w_rbin_next  = r_rbin + PW'(w_ren);
    w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;
  end

  always_ff @(posedge r_clk) begin
    if (rst) begin
      r_rbin  <= '0;
      r_rptr  <= '0;
      r_empty <= 1'b1;
    end else begin
      r_rbin  <= w_rbin_next;
      r_rptr  <= w_rgray_next;
      r_empty <= (w_rgray_next == r_wq2);
    end
  end

  // Output buffer: r_buf0 is the head; capture lands in the first free slot after pop
  always_ff @(posedge r_clk) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_buf0     <= '0;
      r_buf1     <= '0;
    end else begin
      r_inflight <= w_ren;
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_buf0 <= rdata;
          end else begin
            r_buf1 <= rdata;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_buf0 <= rdata;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ren        = w_ren;
  assign raddr      = r_rbin[AW-1:0];
  assign rptr       = r_rptr;
  assign empty      = r_empty;
  assign dout       = r_buf0;
  assign dout_valid = w_valid;

`ifdef RD_LEVEL_EN
  logic [PW-1:0] r_rlevel;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g;
    for (int i = 1; i < int'(PW); i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  always_ff @(posedge r_clk) begin
    if (rst) begin
      r_rlevel <= '0;
    end else begin
      r_rlevel <= gray2bin(r_wq2) - w_rbin_next;
    end
  end

  assign rlevel = r_rlevel;
`else
  assign rlevel = '0;
`endif

endmodule

// File: tb/tb_rd_empty_stage.sv
// Scoreboard bench for rd_empty_stage: a RAM model feeds rdata, written words are queued
// and compared in order as the DUT delivers them.
module tb_rd_empty_stage;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned PW    = 4;

  logic             r_clk = 1'b0;
  logic             rst = 1'b1;
  logic [PW-1:0]    wptr_async = '0;
  logic [WIDTH-1:0] rdata = '0;
  logic             dout_ready = 1'b0;
  logic             ren;
  logic [AW-1:0]    raddr;
  logic [PW-1:0]    rptr;
  logic             empty;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [PW-1:0]    rlevel;

  always #5 r_clk = ~r_clk;

  rd_empty_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .r_clk      (r_clk),
    .rst        (rst),
    .wptr_async (wptr_async),
    .rdata      (rdata),
    .dout_ready (dout_ready),
    .ren        (ren),
    .raddr      (raddr),
    .rptr       (rptr),
    .empty      (empty),
    .dout       (dout),
    .dout_valid (dout_valid),
    .rlevel     (rlevel)
  );

  // RAM model with one-cycle read latency
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge r_clk) if (ren) rdata <= mem[raddr];

  int n_checks = 0;
  int n_fail   = 0;

  int exp_q[$];
  int wbin;
  int rd_cnt, rd_idx, n_ren, n_valid, run, max_run;
  logic ren_d1, ren_d2, hold_d;
  logic [WIDTH-1:0] dout_d;
  logic s_empty, s_ren, s_valid;
  logic [AW-1:0] s_raddr;
  logic [PW-1:0] s_rptr, s_rlevel;
  logic [WIDTH-1:0] s_dout;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] to_gray(input int b);
    logic [PW-1:0] v;
    v = PW'(b);
    return v ^ (v >> 1);
  endfunction

  // Per-cycle observation at the falling edge
  task automatic monitor();
    s_empty  = empty;
    s_ren    = ren;
    s_raddr  = raddr;
    s_rptr   = rptr;
    s_valid  = dout_valid;
    s_dout   = dout;
    s_rlevel = rlevel;
    if (rst) begin
      rd_cnt = 0; rd_idx = 0; n_ren = 0; n_valid = 0; run = 0; max_run = 0;
      ren_d1 = 1'b0; ren_d2 = 1'b0; hold_d = 1'b0; dout_d = '0;
      return;
    end
    check_eq("rptr_track", int'(rptr), int'(to_gray(rd_cnt)));
`ifndef RD_LEVEL_EN
    check_eq("rlevel_zero", int'(rlevel), 0);
`endif
    if (ren_d2) check_eq("valid_latency", int'(dout_valid), 1);
    if (hold_d) begin
      check_eq("hold_valid", int'(dout_valid), 1);
      check_eq("hold_dout", int'(dout), int'(dout_d));
    end
    if (ren) begin
      check_eq("no_overrun", int'(rd_cnt < wbin), 1);
      check_eq("raddr_seq", int'(raddr), rd_cnt % int'(DEPTH));
      rd_cnt++;
      n_ren++;
    end
    if (dout_valid) begin
      n_valid++;
      run++;
      if (run > max_run) max_run = run;
      if (dout_ready) begin
        check_eq("pop_in_range", int'(rd_idx < exp_q.size()), 1);
        if (rd_idx < exp_q.size()) check_eq("data", int'(dout), exp_q[rd_idx]);
        rd_idx++;
      end
    end else begin
      run = 0;
    end
    ren_d2 = ren_d1;
    ren_d1 = ren;
    hold_d = dout_valid & ~dout_ready;
    dout_d = dout;
  endtask

  task automatic tick();
    @(negedge r_clk);
    monitor();
    @(posedge r_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_word(input int v);
    mem[wbin % int'(DEPTH)] = WIDTH'(v);
    exp_q.push_back(v);
    wbin++;
    wptr_async = to_gray(wbin);
  endtask

  task automatic write_rand(input int n);
    for (int i = 0; i < n; i++) write_word(int'($urandom_range(0, 15)));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dout_ready = 1'b0;
    wptr_async = '0;
    wbin = 0;
    exp_q.delete();
    ticks(2);
    check_eq("rst_empty", int'(s_empty), 1);
    check_eq("rst_rptr", int'(s_rptr), 0);
    check_eq("rst_raddr", int'(s_raddr), 0);
    check_eq("rst_ren", int'(s_ren), 0);
    check_eq("rst_valid", int'(s_valid), 0);
    check_eq("rst_rlevel", int'(s_rlevel), 0);
    rst = 1'b0;
  endtask

  initial begin
    foreach (mem[i]) mem[i] = '0;

    // Single word: empty drops at the third edge, data two cycles after ren
    do_reset();
    dout_ready = 1'b1;
    write_word(4'hA);
    ticks(3);
    check_eq("single_empty_before", int'(s_empty), 1);
    tick();
    check_eq("single_empty_low", int'(s_empty), 0);
    check_eq("single_ren", int'(s_ren), 1);
    check_eq("single_raddr", int'(s_raddr), 0);
    tick();
    check_eq("single_rptr", int'(s_rptr), 1);
    check_eq("single_empty_again", int'(s_empty), 1);
    check_eq("single_valid_early", int'(s_valid), 0);
    tick();
    check_eq("single_valid", int'(s_valid), 1);
    check_eq("single_dout", int'(s_dout), 10);
    ticks(3);
    check_eq("single_delivered", rd_idx, 1);

    // Burst of 8 at full throughput
    do_reset();
    dout_ready = 1'b1;
    write_rand(8);
    ticks(20);
    check_eq("burst_ren", n_ren, 8);
    check_eq("burst_valid", n_valid, 8);
    check_eq("burst_run", max_run, 8);
    check_eq("burst_rptr", int'(s_rptr), 12);
    check_eq("burst_empty", int'(s_empty), 1);
    check_eq("burst_delivered", rd_idx, 8);

    // Backpressure: only two fetches while the consumer stalls
    do_reset();
    write_rand(3);
    ticks(12);
    check_eq("bp_ren_count", n_ren, 2);
    check_eq("bp_ren_idle", int'(s_ren), 0);
    check_eq("bp_valid", int'(s_valid), 1);
    check_eq("bp_head", int'(s_dout), exp_q[0]);
    dout_ready = 1'b1;
    ticks(10);
    check_eq("bp_ren_total", n_ren, 3);
    check_eq("bp_delivered", rd_idx, 3);

    // Wrap: 16 words with random consumer stalls
    do_reset();
    write_rand(8);
    for (int i = 0; i < 40; i++) begin
      dout_ready = 1'($urandom_range(0, 1));
      tick();
    end
    dout_ready = 1'b1;
    for (int i = 0; i < 30 && rd_cnt < 8; i++) tick();
    check_eq("wrap_first_half", rd_cnt, 8);
    write_rand(8);
    for (int i = 0; i < 40; i++) begin
      dout_ready = 1'($urandom_range(0, 1));
      tick();
    end
    dout_ready = 1'b1;
    ticks(20);
    check_eq("wrap_reads", n_ren, 16);
    check_eq("wrap_delivered", rd_idx, 16);
    check_eq("wrap_rptr", int'(s_rptr), 0);
    check_eq("wrap_empty", int'(s_empty), 1);

    // Level: five words written, two fetched while stalled
    do_reset();
    write_rand(5);
    ticks(12);
    check_eq("lvl_ren_count", n_ren, 2);
`ifdef RD_LEVEL_EN
    check_eq("lvl_rlevel", int'(s_rlevel), 3);
`else
    check_eq("lvl_rlevel", int'(s_rlevel), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
